// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: byte-serial fetch from memory, little-endian assembly,
// valid/stall handshake to decode; IF_ICACHE_EN adds a direct-mapped instruction cache.
module if_stage #(
  parameter int ICACHE_IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] pc_i,
  input  logic        pc_valid_i,
  input  logic        flush_i,
  input  logic        id_stall_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_dv_i,
  input  logic [7:0]  mem_data_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [1:0]  r_k;
  logic        w_start;
  logic        w_byte_wr;
  logic        w_refill;
  logic        w_hit;
  logic [31:0] w_hit_data;

  if (ICACHE_IDX_W < 1 || ICACHE_IDX_W > 29) begin : g_bad_idx_w
    $error("ICACHE_IDX_W out of range");
  end

`ifdef IF_ICACHE_EN
  localparam int SETS  = 1 << ICACHE_IDX_W;
  localparam int TAG_W = 30 - ICACHE_IDX_W;

  logic [TAG_W-1:0]        r_tag  [SETS];
  logic [31:0]             r_data [SETS];
  logic [SETS-1:0]         r_cvalid;
  logic [ICACHE_IDX_W-1:0] w_rd_idx;
  logic [ICACHE_IDX_W-1:0] w_wr_idx;
  logic [31:0]             w_fill_word;

  // Lookup uses the incoming PC so a hit can go straight to HOLD
  assign w_rd_idx    = pc_i[ICACHE_IDX_W+1:2];
  assign w_wr_idx    = r_pc[ICACHE_IDX_W+1:2];
  assign w_hit       = r_cvalid[w_rd_idx] && (r_tag[w_rd_idx] == pc_i[31:ICACHE_IDX_W+2]);
  assign w_hit_data  = r_data[w_rd_idx];
  assign w_fill_word = {mem_data_i, r_inst[23:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cvalid <= '0;
    end else if (rdy && w_refill) begin
      r_cvalid[w_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && w_refill) begin
      r_tag[w_wr_idx]  <= r_pc[31:ICACHE_IDX_W+2];
      r_data[w_wr_idx] <= w_fill_word;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (rdy) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_byte_wr   = 1'b0;
    w_refill    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!flush_i && pc_valid_i) begin
          w_start     = 1'b1;
          w_state_nxt = w_hit ? S_HOLD : S_REQ;
        end
      end
      S_REQ: begin
        w_state_nxt = flush_i ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        // A byte landing in the flush cycle leaves nothing outstanding, so skip DRAIN
        if (flush_i) begin
          w_state_nxt = mem_dv_i ? S_IDLE : S_DRAIN;
        end else if (mem_dv_i) begin
          w_byte_wr = 1'b1;
          if (r_k == 2'd3) begin
            w_refill    = 1'b1;
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (flush_i) begin
          w_state_nxt = S_IDLE;
        end else if (!id_stall_i) begin
          if (pc_valid_i) begin
            w_start     = 1'b1;
            w_state_nxt = w_hit ? S_HOLD : S_REQ;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (mem_dv_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= '0;
      r_inst <= '0;
      r_k    <= '0;
    end else if (rdy) begin
      if (w_start) begin
        r_pc <= pc_i;
        r_k  <= 2'd0;
        if (w_hit) begin
          r_inst <= w_hit_data;
        end
      end
      if (w_byte_wr) begin
        r_inst[{r_k, 3'b000} +: 8] <= mem_data_i;
        r_k                        <= r_k + 2'd1;
      end
    end
  end

  // A flush in REQ withholds the request so no stray byte comes back later
  assign mem_req_o    = rdy && (r_state == S_REQ) && !flush_i;
  assign mem_addr_o   = r_pc + {30'd0, r_k};
  assign stall_o      = (r_state != S_IDLE) || flush_i;
  assign inst_valid_o = (r_state == S_HOLD);
  assign inst_o       = r_inst;
  assign inst_pc_o    = r_pc;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage: directed handshake cases plus randomized
// traffic scored against a transaction-level fetch model.
module tb_if_stage;

  localparam int IDX_W = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        flush_i;
  logic        id_stall_i;
  logic        stall_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_dv_i;
  logic [7:0]  mem_data_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;

  int n_checks = 0;
  int n_fail   = 0;

  if_stage #(.ICACHE_IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .pc_i(pc_i), .pc_valid_i(pc_valid_i),
    .flush_i(flush_i), .id_stall_i(id_stall_i), .stall_o(stall_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_dv_i(mem_dv_i),
    .mem_data_i(mem_data_i), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_valid_o(inst_valid_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory image: byte 0..3 hold a NOP-like 0x00000013, the rest is address-derived
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] b;
    if (a < 32'd4) b = (a == 32'd0) ? 8'h13 : 8'h00;
    else b = a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    return b;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
  endfunction

  // Memory responder: one outstanding read, byte returned lat cycles after its request,
  // held on the bus until a cycle with rdy high takes it
  int          lat_min = 1;
  int          lat_max = 1;
  logic        mem_pend;
  int          mem_rem;
  logic [31:0] mem_paddr;

  initial begin
    mem_dv_i   = 1'b0;
    mem_data_i = 8'h00;
    mem_pend   = 1'b0;
    mem_rem    = 0;
    mem_paddr  = '0;
    forever begin
      @(negedge clk);
      if (mem_dv_i && rdy) mem_pend = 1'b0;
      if (mem_req_o) begin
        if (mem_pend) chk("mem_overlap", 32'd1, 32'd0);
        mem_pend  = 1'b1;
        mem_paddr = mem_addr_o;
        mem_rem   = int'($urandom_range(lat_max, lat_min));
      end
      @(posedge clk);
      #1;
      if (mem_pend && mem_rem > 0) mem_rem--;
      mem_dv_i   = mem_pend && (mem_rem == 0);
      mem_data_i = mem_dv_i ? mem_byte(mem_paddr) : 8'h00;
    end
  end

  // Transaction-level scoreboard: every accepted PC must yield reads pc..pc+3 (on a miss)
  // and then hand decode exactly mem_word(pc), unless a flush cancels it
  logic        m_live = 1'b0;
  logic [31:0] m_pc   = '0;
  int          m_nreq = 0;
  int          m_age  = 0;
  int          n_consumed = 0;

  always @(negedge clk) begin
    if (rst) begin
      m_live = 1'b0;
      m_nreq = 0;
      m_age  = 0;
    end else begin
      if (flush_i) chk("stall_on_flush", 32'(stall_o), 32'd1);
      if (!rdy) chk("req_gated", 32'(mem_req_o), 32'd0);
      if (mem_req_o) begin
        chk("req_live", 32'(m_live), 32'd1);
        chk("req_count", 32'(m_nreq < 4), 32'd1);
        chk("req_addr", mem_addr_o, m_pc + 32'(m_nreq));
        m_nreq++;
      end
      if (rdy && inst_valid_o && !id_stall_i && !flush_i) begin
        chk("consume_live", 32'(m_live), 32'd1);
        chk("consume_pc", inst_pc_o, m_pc);
        chk("consume_inst", inst_o, mem_word(m_pc));
        m_live = 1'b0;
        n_consumed++;
      end
      if (rdy && flush_i) m_live = 1'b0;
      if (rdy && pc_valid_i && !flush_i && (inst_valid_o ? !id_stall_i : !stall_o)) begin
        m_live = 1'b1;
        m_pc   = pc_i;
        m_nreq = 0;
        m_age  = 0;
      end
      if (m_live) begin
        m_age++;
        if (m_age > 300) begin
          chk("fetch_progress", 32'd0, 32'd1);
          m_live = 1'b0;
        end
      end
    end
  end

  task automatic drive(input logic pv, input logic [31:0] pc, input logic ry,
                       input logic fl, input logic ids);
    @(posedge clk);
    #1;
    pc_valid_i = pv;
    pc_i       = pc;
    rdy        = ry;
    flush_i    = fl;
    id_stall_i = ids;
  endtask

  int          res_valid_cyc;
  int          res_nreq;
  int          res_stall;
  logic        res_stall0;
  logic [31:0] res_inst;
  logic [31:0] res_pc;
  logic [31:0] res_addr [4];

  // One fetch with decode always ready; rdy is pulled low in cycles lo_a/lo_b (relative to pc_valid)
  task automatic run_fetch(input logic [31:0] pc, input int lo_a, input int lo_b);
    logic done;
    done          = 1'b0;
    res_valid_cyc = -1;
    res_nreq      = 0;
    res_stall     = 0;
    res_stall0    = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      drive(c == 0, pc, !(c == lo_a || c == lo_b), 1'b0, 1'b0);
      @(negedge clk);
      if (c == 0) res_stall0 = stall_o;
      else if (stall_o) res_stall++;
      if (mem_req_o) begin
        if (res_nreq < 4) res_addr[res_nreq] = mem_addr_o;
        res_nreq++;
      end
      if (inst_valid_o && rdy) begin
        res_valid_cyc = c;
        res_inst      = inst_o;
        res_pc        = inst_pc_o;
        done          = 1'b1;
      end
    end
    if (!done) chk("fetch_timeout", 32'd0, 32'd1);
  endtask

  logic        got;
  logic [31:0] held;
  int          n_stable;
  int          n_st;
  int          n_rq;
  int          n_vl;
  logic        st3;
  logic        st4;

  initial begin
    rst = 1'b1; rdy = 1'b1; pc_i = '0; pc_valid_i = 1'b0; flush_i = 1'b0; id_stall_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_inst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_inst_pc", inst_pc_o, 32'd0);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);

    // Miss path from reset, memory latency 1
    run_fetch(32'h0, -1, -1);
    chk("t1_valid_cycle", 32'(res_valid_cyc), 32'd9);
    chk("t1_inst", res_inst, 32'h0000_0013);
    chk("t1_inst_pc", res_pc, 32'h0);
    chk("t1_nreq", 32'(res_nreq), 32'd4);
    for (int i = 0; i < 4; i++) chk("t1_addr", res_addr[i], 32'(i));
    chk("t1_stall_n0", 32'(res_stall0), 32'd0);
    chk("t1_stall_n1_n9", 32'(res_stall), 32'd9);

    // Decode stall for three HOLD cycles
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      drive(c == 0, 32'h80, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      if (inst_valid_o) got = 1'b1;
    end
    chk("t2_reach_hold", 32'(got), 32'd1);
    held     = inst_o;
    n_stable = 1;
    n_st     = stall_o ? 1 : 0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      if (inst_valid_o && inst_o === held) n_stable++;
      if (stall_o) n_st++;
    end
    chk("t2_inst", held, mem_word(32'h80));
    chk("t2_stable", 32'(n_stable), 32'd3);
    chk("t2_stall", 32'(n_st), 32'd3);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_valid_4th", 32'(inst_valid_o), 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_consumed", 32'(inst_valid_o), 32'd0);

    // Flush while byte 2 of 0x100 is outstanding (latency 3 forces DRAIN)
    lat_min = 3; lat_max = 3;
    got  = 1'b0;
    n_rq = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      drive(c == 0, 32'h100, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      if (mem_req_o) begin
        n_rq++;
        if (n_rq == 3) got = 1'b1;
      end
    end
    chk("t3_third_req", 32'(got), 32'd1);
    chk("t3_third_addr", mem_addr_o, 32'h102);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    n_rq = 0; n_vl = 0; st3 = 1'b0; st4 = 1'b1;
    for (int i = 2; i < 11; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      if (i == 3) st3 = stall_o;
      if (i == 4) st4 = stall_o;
      if (mem_req_o) n_rq++;
      if (inst_valid_o) n_vl++;
    end
    chk("t3_drain_stall", 32'(st3), 32'd1);
    chk("t3_drain_exit", 32'(st4), 32'd0);
    chk("t3_no_valid", 32'(n_vl), 32'd0);
    chk("t3_no_req", 32'(n_rq), 32'd0);
    lat_min = 1; lat_max = 1;
    run_fetch(32'h200, -1, -1);
    chk("t3_next_addr", res_addr[0], 32'h200);
    chk("t3_next_inst", res_inst, mem_word(32'h200));
    chk("t3_next_pc", res_pc, 32'h200);

    // Flush in HOLD with a simultaneous PC that must be dropped
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      drive(c == 0, 32'h300, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      if (inst_valid_o) got = 1'b1;
    end
    chk("t4_reach_hold", 32'(got), 32'd1);
    drive(1'b1, 32'h400, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_valid_dropped", 32'(inst_valid_o), 32'd0);
    chk("t4_idle", 32'(stall_o), 32'd0);
    n_rq = mem_req_o ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      if (mem_req_o) n_rq++;
    end
    chk("t4_pc_dropped", 32'(n_rq), 32'd0);

    // Cache hit and index aliasing
    run_fetch(32'h40, -1, -1);
    chk("t5_first_miss", 32'(res_nreq), 32'd4);
    run_fetch(32'h40, -1, -1);
    chk("t5_second_inst", res_inst, mem_word(32'h40));
`ifdef IF_ICACHE_EN
    chk("t5_hit_latency", 32'(res_valid_cyc), 32'd1);
    chk("t5_hit_no_req", 32'(res_nreq), 32'd0);
`else
    chk("t5_nocache_latency", 32'(res_valid_cyc), 32'd9);
    chk("t5_nocache_req", 32'(res_nreq), 32'd4);
`endif
    run_fetch(32'h40 + (32'd4 << IDX_W), -1, -1);
    chk("t5_alias_miss", 32'(res_nreq), 32'd4);
    chk("t5_alias_inst", res_inst, mem_word(32'h140));
    run_fetch(32'h140, -1, -1);
`ifdef IF_ICACHE_EN
    chk("t5_refill_hit", 32'(res_valid_cyc), 32'd1);
`else
    chk("t5_refill_nocache", 32'(res_valid_cyc), 32'd9);
`endif

    // Address wrap with rdy low for two cycles mid-fetch
    run_fetch(32'hFFFF_FFFC, 3, 6);
    chk("t6_valid_cycle", 32'(res_valid_cyc), 32'd11);
    chk("t6_nreq", 32'(res_nreq), 32'd4);
    for (int i = 0; i < 4; i++) chk("t6_addr", res_addr[i], 32'hFFFF_FFFC + 32'(i));
    chk("t6_inst", res_inst, mem_word(32'hFFFF_FFFC));

    // Reset mid-fetch; the late byte lands in IDLE and must be ignored
    lat_min = 3; lat_max = 3;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      drive(c == 0, 32'h600, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      if (mem_req_o) got = 1'b1;
    end
    chk("t7_req_seen", 32'(got), 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t7_rst_pc", inst_pc_o, 32'h0);
    chk("t7_rst_stall", 32'(stall_o), 32'd0);
    n_vl = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      if (inst_valid_o || mem_req_o) n_vl++;
    end
    chk("t7_quiet_after_rst", 32'(n_vl), 32'd0);
    lat_min = 1; lat_max = 1;
    run_fetch(32'h500, -1, -1);
    chk("t7_fetch_inst", res_inst, mem_word(32'h500));
    chk("t7_fetch_latency", 32'(res_valid_cyc), 32'd9);

    // Randomized traffic scored by the monitor
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rpc;
      case ($urandom_range(5, 0))
        0:       rpc = 32'h40;
        1:       rpc = 32'h140;
        2:       rpc = 32'hFFFF_FFFC;
        3:       rpc = 32'h1000 + ($urandom_range(7, 0) << 2);
        default: rpc = $urandom & 32'hFFFF_FFFC;
      endcase
      drive(($urandom % 3) == 0, rpc, ($urandom % 10) != 0, ($urandom % 25) == 0,
            ($urandom % 4) == 0);
    end
    for (int i = 0; i < 80; i++) drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("rand_all_done", 32'(m_live), 32'd0);
    chk("rand_traffic", 32'(n_consumed > 30), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the CPU pipeline, directly downstream of the PC register. It accepts one fetch PC per valid pulse and fetches the 32-bit instruction as four byte reads from the memory controller. It assembles the bytes little-endian and presents instruction plus PC to the decode stage with a valid/stall handshake. While busy it back-pressures the PC register through `stall_o`; an optional direct-mapped instruction cache short-circuits the memory access.

## Interface
- `ICACHE_IDX_W`, 6: cache index width; 2^ICACHE_IDX_W entries. Only used with `ICACHE_EN`.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global ready. Low freezes all state and outputs; `mem_req_o` is forced 0 combinationally.
- `pc_i` in 32: fetch address, word aligned.
- `pc_valid_i` in 1: one-cycle pulse, `pc_i` valid. Connects to the PC register's ready output.
- `flush_i` in 1: jump redirect; abort the current fetch and drop any held instruction.
- `id_stall_i` in 1: decode cannot accept this cycle.
- `stall_o` out 1: to the PC register stall input.
- `mem_req_o` out 1: byte read request.
- `mem_addr_o` out 32: byte address for `mem_req_o`.
- `mem_dv_i` in 1: returned byte valid, at least 1 cycle after the request cycle.
- `mem_data_i` in 8: returned byte.
- `inst_o` out 32: fetched instruction.
- `inst_pc_o` out 32: PC of `inst_o`.
- `inst_valid_o` out 1: `inst_o`/`inst_pc_o` valid.

## Operation
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- **IDLE**
  - On `pc_valid_i`, latch `pc_i`.
  - Cache hit (`ICACHE_EN`): go to HOLD with the cached word.
  - Otherwise: set byte index k=0 and go to REQ.
- **REQ**
  - Assert `mem_req_o` for exactly one cycle with `mem_addr_o` = pc+k, then go to WAIT.
- **WAIT**
  - On `mem_dv_i`, write `mem_data_i` into bits [8k+7:8k].
  - k<3: increment k and go to REQ.
  - k=3: go to HOLD.
- **HOLD**
  - `inst_valid_o`=1.
  - If `id_stall_i`=0, the instruction is consumed at this edge. Next state is IDLE; if `pc_valid_i` is also high, it starts the next fetch directly (same rules as IDLE).
  - If `id_stall_i`=1, hold outputs stable.
- **DRAIN**
  - Entered on `flush_i` while a byte request is outstanding (WAIT).
  - Wait for `mem_dv_i`, discard the byte, then go to IDLE.
- **Flush**
  - `flush_i` in IDLE, REQ or HOLD: go to IDLE next cycle and clear `inst_valid_o`.
  - A flush takes priority over `pc_valid_i` in the same cycle; that PC is dropped.
- **Stall:** `stall_o` = (state ≠ IDLE) || `flush_i` — combinational.
- `mem_addr_o` = latched pc + k, 32-bit wrap-around arithmetic.
- Cache refill on a memory-completed word: write tag pc[31:ICACHE_IDX_W+2], index pc[ICACHE_IDX_W+1:2], data, and valid.
- Cache valid bits clear on `rst`; `flush_i` does not clear the cache.

## Timing
- Reset values:
  - state IDLE;
  - `inst_valid_o`=0, `inst_o`=0, `inst_pc_o`=0;
  - `mem_req_o`=0, `mem_addr_o`=0;
  - `stall_o`=0 (unless `flush_i`).
- Miss latency, with memory returning each byte 1 cycle after its request:
  - `pc_valid_i` in cycle N → REQ in N+1, byte 0 in N+2, …;
  - `inst_valid_o` rises in cycle N+9.
- Hit latency: `pc_valid_i` in cycle N → `inst_valid_o` in cycle N+1.
- `rst` has priority over everything, including a mid-fetch DRAIN. A byte returned after reset is ignored.
- `rdy`=0: all registers hold; a pending `mem_dv_i` is not sampled.

## Configuration
- `IF_ICACHE_EN` defined: direct-mapped instruction cache (tag + valid + 32-bit data per entry) with the hit/refill behaviour above.
- `IF_ICACHE_EN` undefined:
  - no cache storage;
  - every fetch takes the miss path;
  - `ICACHE_IDX_W` is ignored.

## Test plan
- **Reset:** reset, then `pc_i`=0x0 valid; memory returns bytes 0x13,0x00,0x00,0x00.
  - `mem_addr_o` sequence 0,1,2,3;
  - `inst_o`=0x00000013, `inst_pc_o`=0 at cycle N+9;
  - `stall_o` high N+1..N+9.
- **Decode stall:** `id_stall_i`=1 for 3 cycles while in HOLD.
  - `inst_o` stable for 3 cycles;
  - `stall_o`=1 throughout;
  - consumed on the 4th cycle.
- **Flush during fetch:** `flush_i` while waiting on byte 2 at pc 0x100.
  - Enter DRAIN; the late byte is discarded;
  - no `inst_valid_o`;
  - next `pc_i`=0x200 fetches from 0x200.
- **Flush in HOLD:** `flush_i` while in HOLD.
  - `inst_valid_o` drops the next cycle;
  - state IDLE;
  - a simultaneous `pc_valid_i` is ignored.
- **Cache hit (`IF_ICACHE_EN`):** fetch 0x40 twice.
  - Second fetch produces `inst_valid_o` 1 cycle after `pc_valid_i`, with no `mem_req_o`.
  - 0x40+(4<<ICACHE_IDX_W) aliases to the same index: miss, then refill.
- **Address wrap:** `pc_i`=0xFFFFFFFC → addresses FFFFFFFC..FFFFFFFF.
  - With `rdy` toggled low mid-fetch, the result is the same word, one cycle later per low cycle.
